// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: holds the MMCM in reset, read-modify-writes the four
// CLKOUT0/CLKOUT1 divide registers over DRP, releases reset and waits for lock.
// The clk input also drives the MMCM DCLK.
// Optional feature macro: MMCM_DRP_AUTOSTART_EN (self-start with config 0 after reset).
module mmcm_drp_reconfig #(
    parameter int unsigned CFG0_DIV0    = 20,
    parameter int unsigned CFG0_DIV1    = 12,
    parameter int unsigned CFG1_DIV0    = 10,
    parameter int unsigned CFG1_DIV1    = 15,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cfg_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [6:0]  daddr,
    output logic [15:0] di,
    output logic        den,
    output logic        dwe,
    input  logic [15:0] do_in,
    input  logic        drdy,
    output logic        mmcm_rst,
    input  logic        locked
);

    localparam int unsigned TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASSERT,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RELEASE,
        S_LOCK_WAIT
    } state_t;

    // ClkReg1 image: high time in [11:6], low time in [5:0], phase mux bits zero
    function automatic logic [15:0] reg1_data(input logic [6:0] d);
        logic [6:0] hi;
        logic [6:0] lo;
        hi = d >> 1;
        lo = d - hi;
        return {3'b000, 1'b0, hi[5:0], lo[5:0]};
    endfunction

    // ClkReg2 image: edge bit set for odd divides, no_count cleared
    function automatic logic [15:0] reg2_data(input logic [6:0] d);
        return {8'h00, d[0], 1'b0, 6'b000000};
    endfunction

    localparam logic [6:0] C0_D0 = 7'(CFG0_DIV0);
    localparam logic [6:0] C0_D1 = 7'(CFG0_DIV1);
    localparam logic [6:0] C1_D0 = 7'(CFG1_DIV0);
    localparam logic [6:0] C1_D1 = 7'(CFG1_DIV1);

    state_t        state;
    state_t        state_next;
    logic          cfg_q;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [TW-1:0] timer;
    logic          locked_m;
    logic          locked_s;
    logic          go;
    logic          go_sel;
    logic          drdy_hit;
    logic          lock_hit;
    logic          timeout_exit;

    logic [6:0]    tbl_addr;
    logic [15:0]   tbl_mask;
    logic [15:0]   tbl_data;
    logic [6:0]    div0_sel;
    logic [6:0]    div1_sel;

    logic          busy_d;
    logic          done_d;
    logic          err_d;
    logic [6:0]    daddr_d;
    logic [15:0]   di_d;
    logic          den_d;
    logic          dwe_d;
    logic          mmcm_rst_d;

`ifdef MMCM_DRP_AUTOSTART_EN
    logic auto_pend;

    // One-shot request in the first cycle after reset; overrides any start pulse
    always_ff @(posedge clk) begin
        if (rst) auto_pend <= 1'b1;
        else     auto_pend <= 1'b0;
    end

    assign go     = auto_pend | start;
    assign go_sel = auto_pend ? 1'b0 : cfg_sel;
`else
    assign go     = start;
    assign go_sel = cfg_sel;
`endif

    assign drdy_hit = (timer == TW'(DRDY_TIMEOUT));
    assign lock_hit = (timer == TW'(LOCK_TIMEOUT));

    // Register table lookup for the entry about to be accessed
    always_comb begin
        div0_sel = cfg_q ? C1_D0 : C0_D0;
        div1_sel = cfg_q ? C1_D1 : C0_D1;
        tbl_addr = 7'h08;
        tbl_mask = 16'h1000;
        tbl_data = reg1_data(div0_sel);
        case (idx_next)
            2'd0: begin
                tbl_addr = 7'h08;
                tbl_mask = 16'h1000;
                tbl_data = reg1_data(div0_sel);
            end
            2'd1: begin
                tbl_addr = 7'h09;
                tbl_mask = 16'hFF00;
                tbl_data = reg2_data(div0_sel);
            end
            2'd2: begin
                tbl_addr = 7'h0A;
                tbl_mask = 16'h1000;
                tbl_data = reg1_data(div1_sel);
            end
            default: begin
                tbl_addr = 7'h0B;
                tbl_mask = 16'hFF00;
                tbl_data = reg2_data(div1_sel);
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and register-index logic; drdy on the timeout cycle wins
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        timeout_exit = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_next = S_ASSERT;
                    idx_next   = 2'd0;
                end
            end
            S_ASSERT: state_next = S_RD;
            S_RD:     state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (drdy) begin
                    state_next = S_WR;
                end else if (drdy_hit) begin
                    state_next   = S_IDLE;
                    timeout_exit = 1'b1;
                end
            end
            S_WR: state_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drdy) begin
                    if (idx == 2'd3) begin
                        state_next = S_RELEASE;
                    end else begin
                        state_next = S_RD;
                        idx_next   = idx + 2'd1;
                    end
                end else if (drdy_hit) begin
                    state_next   = S_IDLE;
                    timeout_exit = 1'b1;
                end
            end
            S_RELEASE: state_next = S_LOCK_WAIT;
            S_LOCK_WAIT: begin
                if (locked_s) begin
                    state_next = S_IDLE;
                end else if (lock_hit) begin
                    state_next   = S_IDLE;
                    timeout_exit = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: next-cycle values of the registered outputs
    always_comb begin
        busy_d     = (state_next != S_IDLE);
        done_d     = (state == S_LOCK_WAIT) && locked_s;
        err_d      = err;
        daddr_d    = daddr;
        di_d       = di;
        den_d      = (state_next == S_RD) || (state_next == S_WR);
        dwe_d      = (state_next == S_WR);
        mmcm_rst_d = (state_next == S_ASSERT) || (state_next == S_RD) ||
                     (state_next == S_RD_WAIT) || (state_next == S_WR) ||
                     (state_next == S_WR_WAIT);
        if ((state == S_IDLE) && go) err_d = 1'b0;
        if (timeout_exit)            err_d = 1'b1;
        if (state_next == S_RD)      daddr_d = tbl_addr;
        if ((state == S_RD_WAIT) && drdy) di_d = (do_in & tbl_mask) | tbl_data;
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            daddr    <= 7'h00;
            di       <= 16'h0000;
            den      <= 1'b0;
            dwe      <= 1'b0;
            mmcm_rst <= 1'b0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            daddr    <= daddr_d;
            di       <= di_d;
            den      <= den_d;
            dwe      <= dwe_d;
            mmcm_rst <= mmcm_rst_d;
        end
    end

    // Config capture, entry index and per-wait timer (reloads on every state change)
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= 1'b0;
            idx   <= 2'd0;
            timer <= '0;
        end else begin
            if ((state == S_IDLE) && go) cfg_q <= go_sel;
            idx <= idx_next;
            if (state_next != state) timer <= TW'(1);
            else                     timer <= timer + TW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous LOCKED input
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

endmodule
